sram_responder: RTL and testbench

- Synthesizable model of the external 16-bit asynchronous-style SRAM, sitting on the far side of the pin bundle that the MEM stage drives.
- Responds to that stage's two-halfword 32-bit accesses: captures byte-lane writes, returns read data on the shared tri-state DQ bus after a fixed registered latency.
- Provides a backdoor port for bench preload and inspection, plus access counters and a bus-contention flag.
- Used in simulation and FPGA loopback in place of the board SRAM.

---
 rtl/sram_responder.sv | 134 +++++++++++++
 tb/tb_sram_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// sram_responder: behavioural 16-bit asynchronous-style SRAM seen from the pin side.
// Byte-lane writes, registered read pipeline driving a shared tri-state DQ bus,
// a backdoor port for preload/inspection, saturating access counters and a
// sticky contention flag.
module sram_responder #(
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  inout  wire logic [15:0]      sramDQ,
  input  logic [ADDR_W-1:0]     sramAddr,
  input  logic                  sramWE,
  input  logic                  sramCE,
  input  logic                  sramOE,
  input  logic                  sramLB,
  input  logic                  sramUB,
  input  logic                  bd_en,
  input  logic                  bd_we,
  input  logic [DEPTH_LOG2-1:0] bd_addr,
  input  logic [15:0]           bd_wdata,
  output logic [15:0]           bd_rdata,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count,
  output logic                  contention
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  logic [15:0] mem [Depth];

  logic [DEPTH_LOG2-1:0] fd_addr;
  logic                  fd_rd, fd_wr, fd_wr_lo, fd_wr_hi;
  logic                  unused_addr_hi;

  // Upper address bits are ignored so accesses alias modulo the depth.
  assign fd_addr        = sramAddr[DEPTH_LOG2-1:0];
  assign unused_addr_hi = ^sramAddr[ADDR_W-1:DEPTH_LOG2];

  assign fd_rd    = !sramCE && !sramWE;
  assign fd_wr    = !sramCE && sramWE;
  assign fd_wr_lo = fd_wr && !sramLB;
  assign fd_wr_hi = fd_wr && !sramUB;

  // Read pipeline: stage 0 captures, last stage feeds the DQ drivers.
  logic [READ_LAT-1:0] pipe_vld_q;
  logic [15:0]         pipe_dat_q [READ_LAT];
  logic                pipe_out_vld;
  logic [15:0]         pipe_out_dat;

  assign pipe_out_vld = pipe_vld_q[READ_LAT-1];
  assign pipe_out_dat = pipe_dat_q[READ_LAT-1];

  // Full 16 bits are driven on a read; byte lanes only qualify writes.
  assign sramDQ = (pipe_out_vld && !sramOE && !sramWE && !sramCE) ? pipe_out_dat
                                                                  : {16{1'bz}};

  // Array update: backdoor first so front-door lanes override it on the same word.
  always_ff @(posedge clk) begin
    if (bd_en && bd_we) begin
      mem[bd_addr] <= bd_wdata;
    end
    if (fd_wr_lo) begin
      mem[fd_addr][7:0] <= sramDQ[7:0];
    end
    if (fd_wr_hi) begin
      mem[fd_addr][15:8] <= sramDQ[15:8];
    end
  end

  // Shift read captures through the latency pipeline; reset discards pending reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_vld_q <= '0;
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        pipe_dat_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= fd_rd;
      pipe_dat_q[0] <= mem[fd_addr];
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_dat_q[i] <= pipe_dat_q[i-1];
      end
    end
  end

  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;
  logic [15:0] bd_rdata_q, bd_rdata_d;
  logic        contention_q, contention_d;

  // Next-state for counters (saturating), backdoor read data and sticky flag.
  always_comb begin
    rd_count_d   = rd_count_q;
    wr_count_d   = wr_count_q;
    bd_rdata_d   = bd_rdata_q;
    contention_d = contention_q;
    if (fd_rd && rd_count_q != 16'hFFFF) begin
      rd_count_d = rd_count_q + 16'd1;
    end
    if ((fd_wr_lo || fd_wr_hi) && wr_count_q != 16'hFFFF) begin
      wr_count_d = wr_count_q + 16'd1;
    end
    if (bd_en && !bd_we) begin
      bd_rdata_d = mem[bd_addr];
    end
    if (sramWE && pipe_out_vld) begin
      contention_d = 1'b1;
    end
  end

  // Status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count_q   <= '0;
      wr_count_q   <= '0;
      bd_rdata_q   <= '0;
      contention_q <= 1'b0;
    end else begin
      rd_count_q   <= rd_count_d;
      wr_count_q   <= wr_count_d;
      bd_rdata_q   <= bd_rdata_d;
      contention_q <= contention_d;
    end
  end

  assign rd_count   = rd_count_q;
  assign wr_count   = wr_count_q;
  assign bd_rdata   = bd_rdata_q;
  assign contention = contention_q;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: one READ_LAT=1 and one READ_LAT=3 instance share all
// control inputs; each has its own pulled-up DQ bus so a released bus reads FFFF.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [17:0] sramAddr = '0;
  logic        sramWE = 1'b0, sramCE = 1'b1, sramOE = 1'b1, sramLB = 1'b1, sramUB = 1'b1;
  logic        bd_en = 1'b0, bd_we = 1'b0;
  logic [9:0]  bd_addr = '0;
  logic [15:0] bd_wdata = '0;
  logic [15:0] tb_dq = '0;

  tri1 [15:0] sramDQ;
  tri1 [15:0] sramDQ3;
  logic [15:0] bd_rdata, rd_count, wr_count, bd_rdata3, rd_count3, wr_count3;
  logic        contention, contention3;

  assign sramDQ  = sramWE ? tb_dq : 16'hzzzz;
  assign sramDQ3 = sramWE ? tb_dq : 16'hzzzz;

  always #5 clk = ~clk;

  sram_responder #(.ADDR_W(18), .DEPTH_LOG2(10), .READ_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .sramDQ(sramDQ), .sramAddr(sramAddr), .sramWE(sramWE),
    .sramCE(sramCE), .sramOE(sramOE), .sramLB(sramLB), .sramUB(sramUB), .bd_en(bd_en),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata),
    .rd_count(rd_count), .wr_count(wr_count), .contention(contention)
  );

  sram_responder #(.ADDR_W(18), .DEPTH_LOG2(10), .READ_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .sramDQ(sramDQ3), .sramAddr(sramAddr), .sramWE(sramWE),
    .sramCE(sramCE), .sramOE(sramOE), .sramLB(sramLB), .sramUB(sramUB), .bd_en(bd_en),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata3),
    .rd_count(rd_count3), .wr_count(wr_count3), .contention(contention3)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: word array plus a log of read captures keyed by edge number.
  logic [15:0] mm [1024];
  logic [15:0] cap [int];
  int          edge_n = 0;
  logic [15:0] m_rd = '0, m_wr = '0, m_bd = '0;
  logic        m_cont1 = 1'b0, m_cont3 = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // A read captured at edge k is on the pipe output after edge k+lat-1.
  function automatic bit pipe_valid(input int lat);
    return cap.exists(edge_n - lat + 1);
  endfunction

  function automatic logic [15:0] exp_dq(input int lat);
    if (sramWE) return tb_dq;
    if (!sramCE && !sramOE && pipe_valid(lat)) return cap[edge_n - lat + 1];
    return 16'hFFFF;
  endfunction

  task automatic model_reset();
    cap.delete();
    m_rd = '0; m_wr = '0; m_bd = '0; m_cont1 = 1'b0; m_cont3 = 1'b0;
  endtask

  // Compare both instances against the model, away from the clock edge.
  task automatic sample();
    @(negedge clk);
    chk("dq_lat1", sramDQ, exp_dq(1));
    chk("dq_lat3", sramDQ3, exp_dq(3));
    chk("rd_count", rd_count, m_rd);
    chk("rd_count3", rd_count3, m_rd);
    chk("wr_count", wr_count, m_wr);
    chk("wr_count3", wr_count3, m_wr);
    chk("bd_rdata", bd_rdata, m_bd);
    chk("bd_rdata3", bd_rdata3, m_bd);
    chk("contention", {15'd0, contention}, {15'd0, m_cont1});
    chk("contention3", {15'd0, contention3}, {15'd0, m_cont3});
  endtask

  // Advance one clock edge and apply its effect to the model.
  task automatic tick();
    int a;
    @(posedge clk);
    a = int'(sramAddr[9:0]);
    if (sramWE && pipe_valid(1)) m_cont1 = 1'b1;
    if (sramWE && pipe_valid(3)) m_cont3 = 1'b1;
    if (bd_en && !bd_we) m_bd = mm[bd_addr];
    if (!sramCE && !sramWE) begin
      cap[edge_n + 1] = mm[a];
      if (m_rd != 16'hFFFF) m_rd = m_rd + 16'd1;
    end
    if (bd_en && bd_we) mm[bd_addr] = bd_wdata;
    if (!sramCE && sramWE) begin
      if (!sramLB) mm[a][7:0] = tb_dq[7:0];
      if (!sramUB) mm[a][15:8] = tb_dq[15:8];
      if ((!sramLB || !sramUB) && m_wr != 16'hFFFF) m_wr = m_wr + 16'd1;
    end
    edge_n++;
    #1;
  endtask

  task automatic drive(input logic ce, input logic we, input logic oe, input logic lb,
                       input logic ub, input logic [17:0] addr, input logic [15:0] dq,
                       input logic ben, input logic bwe, input logic [9:0] badr,
                       input logic [15:0] bwd);
    sramCE = ce; sramWE = we; sramOE = oe; sramLB = lb; sramUB = ub;
    sramAddr = addr; tb_dq = dq;
    bd_en = ben; bd_we = bwe; bd_addr = badr; bd_wdata = bwd;
  endtask

  task automatic idle();
    drive(1, 0, 1, 1, 1, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic rd(input logic [17:0] addr);
    drive(0, 0, 0, 1, 1, addr, '0, 0, 0, '0, '0);
  endtask

  typedef struct packed {
    logic        ce, we, oe, lb, ub;
    logic [17:0] addr;
    logic [15:0] dq;
    logic        bd_en, bd_we;
    logic [9:0]  bd_addr;
    logic [15:0] bd_wdata;
    logic [15:0] x_dq, x_rd, x_wr, x_bd;
  } vec_t;

  function automatic vec_t mk(input logic ce, input logic we, input logic oe, input logic lb,
                              input logic ub, input logic [17:0] addr, input logic [15:0] dq,
                              input logic ben, input logic bwe, input logic [9:0] badr,
                              input logic [15:0] bwd, input logic [15:0] xdq,
                              input logic [15:0] xrd, input logic [15:0] xwr,
                              input logic [15:0] xbd);
    vec_t v;
    v.ce = ce; v.we = we; v.oe = oe; v.lb = lb; v.ub = ub; v.addr = addr; v.dq = dq;
    v.bd_en = ben; v.bd_we = bwe; v.bd_addr = badr; v.bd_wdata = bwd;
    v.x_dq = xdq; v.x_rd = xrd; v.x_wr = xwr; v.x_bd = xbd;
    return v;
  endfunction

  vec_t tbl [16];

  initial begin
    // Expected values for the READ_LAT=1 instance, sampled before each row's edge.
    tbl[0]  = mk(1,0,1,1,1, 18'd0,     16'h0000, 1,1,10'd5,16'hBEEF, 16'hFFFF,16'd0,16'd0,16'h0000);
    tbl[1]  = mk(0,0,0,1,1, 18'd5,     16'h0000, 0,0,10'd0,16'h0000, 16'hFFFF,16'd0,16'd0,16'h0000);
    tbl[2]  = mk(0,0,0,1,1, 18'd5,     16'h0000, 0,0,10'd0,16'h0000, 16'hBEEF,16'd1,16'd0,16'h0000);
    tbl[3]  = mk(1,0,1,1,1, 18'd0,     16'h0000, 0,0,10'd0,16'h0000, 16'hFFFF,16'd2,16'd0,16'h0000);
    tbl[4]  = mk(0,1,1,0,1, 18'd6,     16'h1234, 0,0,10'd0,16'h0000, 16'h1234,16'd2,16'd0,16'h0000);
    tbl[5]  = mk(0,1,1,1,0, 18'd6,     16'hAB00, 0,0,10'd0,16'h0000, 16'hAB00,16'd2,16'd1,16'h0000);
    tbl[6]  = mk(1,0,1,1,1, 18'd0,     16'h0000, 1,0,10'd6,16'h0000, 16'hFFFF,16'd2,16'd2,16'h0000);
    tbl[7]  = mk(0,1,1,0,0, 18'd8,     16'hF00D, 0,0,10'd0,16'h0000, 16'hF00D,16'd2,16'd2,16'hAB34);
    tbl[8]  = mk(0,1,1,0,0, 18'd9,     16'hCAFE, 0,0,10'd0,16'h0000, 16'hCAFE,16'd2,16'd3,16'hAB34);
    tbl[9]  = mk(0,0,0,1,1, 18'd8,     16'h0000, 0,0,10'd0,16'h0000, 16'hFFFF,16'd2,16'd4,16'hAB34);
    tbl[10] = mk(0,0,0,1,1, 18'd9,     16'h0000, 0,0,10'd0,16'h0000, 16'hF00D,16'd3,16'd4,16'hAB34);
    tbl[11] = mk(0,0,0,1,1, 18'd8,     16'h0000, 0,0,10'd0,16'h0000, 16'hCAFE,16'd4,16'd4,16'hAB34);
    tbl[12] = mk(1,0,1,1,1, 18'd0,     16'h0000, 0,0,10'd0,16'h0000, 16'hFFFF,16'd5,16'd4,16'hAB34);
    tbl[13] = mk(0,1,1,0,0, 18'h00401, 16'h5A5A, 0,0,10'd0,16'h0000, 16'h5A5A,16'd5,16'd4,16'hAB34);
    tbl[14] = mk(1,0,1,1,1, 18'd0,     16'h0000, 1,0,10'd1,16'h0000, 16'hFFFF,16'd5,16'd5,16'hAB34);
    tbl[15] = mk(1,0,1,1,1, 18'd0,     16'h0000, 0,0,10'd0,16'h0000, 16'hFFFF,16'd5,16'd5,16'h5A5A);

    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Preload the low 16 words through the backdoor so the model knows them.
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 1, 1, 1, '0, '0, 1, 1, 10'(i), 16'(i * 16'h0731 + 16'h0102));
      sample();
      tick();
    end

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].ce, tbl[i].we, tbl[i].oe, tbl[i].lb, tbl[i].ub, tbl[i].addr, tbl[i].dq,
            tbl[i].bd_en, tbl[i].bd_we, tbl[i].bd_addr, tbl[i].bd_wdata);
      sample();
      chk($sformatf("tbl%0d_dq", i), sramDQ, tbl[i].x_dq);
      chk($sformatf("tbl%0d_rd", i), rd_count, tbl[i].x_rd);
      chk($sformatf("tbl%0d_wr", i), wr_count, tbl[i].x_wr);
      chk($sformatf("tbl%0d_bd", i), bd_rdata, tbl[i].x_bd);
      chk($sformatf("tbl%0d_cont", i), {15'd0, contention}, 16'd0);
      tick();
    end

    // Three-cycle latency: back-to-back reads of 1,2,3 come out in order.
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 1, 1, 1, '0, '0, 1, 1, 10'(i), 16'(i * 16'h0011));
      sample();
      tick();
    end
    idle();
    repeat (3) begin sample(); tick(); end
    for (int i = 1; i <= 3; i++) begin
      rd(18'(i));
      sample();
      chk("lat3_early", sramDQ3, 16'hFFFF);
      tick();
    end
    for (int i = 1; i <= 3; i++) begin
      rd(18'd0);
      sample();
      chk("lat3_order", sramDQ3, 16'(i * 16'h0011));
      tick();
    end
    idle();
    sample();
    chk("lat3_release", sramDQ3, 16'hFFFF);
    tick();

    // Write strobe while a read is still on the bus sets the sticky flag.
    rd(18'd4);
    sample();
    chk("cont_before", {15'd0, contention}, 16'd0);
    tick();
    drive(0, 1, 1, 1, 1, 18'd4, 16'h0000, 0, 0, '0, '0);
    sample();
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("cont_sticky", {15'd0, contention}, 16'd1);
      tick();
    end

    // Reset asserted while both pipelines are driving: bus releases at once.
    for (int i = 0; i < 3; i++) begin
      rd(18'd1);
      sample();
      tick();
    end
    rd(18'd1);
    sample();
    chk("pre_rst_dq", sramDQ, 16'h0011);
    chk("pre_rst_dq3", sramDQ3, 16'h0011);
    rst = 1'b0;
    #1;
    chk("rst_dq", sramDQ, 16'hFFFF);
    chk("rst_dq3", sramDQ3, 16'hFFFF);
    chk("rst_rd", rd_count, 16'd0);
    chk("rst_wr", wr_count, 16'd0);
    chk("rst_bd", bd_rdata, 16'd0);
    chk("rst_cont", {15'd0, contention}, 16'd0);
    chk("rst_cont3", {15'd0, contention3}, 16'd0);
    model_reset();
    #1;
    rst = 1'b1;
    idle();
    tick();

    // Randomised traffic over 16 words reached through aliased addresses.
    for (int i = 0; i < 400; i++) begin
      logic [17:0] ra;
      ra = {8'($urandom), 6'd0, 4'($urandom)};
      drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), ra, 16'($urandom),
            1'($urandom), 1'($urandom), 10'($urandom_range(0, 15)), 16'($urandom));
      sample();
      tick();
    end
    idle();
    sample();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
